// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, field/immediate decode, 32x32 register file
// with write-through bypass, and load-use hazard detection that stalls fetch.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter bit          REG_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_imm,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] rf_q [32];

  logic        use_rs1, use_rs2, known_op, hazard, hold;
  logic [31:0] imm;

  assign id_opcode = instr_q[6:0];
  assign id_rd     = instr_q[11:7];
  assign id_funct3 = instr_q[14:12];
  assign id_rs1    = instr_q[19:15];
  assign id_rs2    = instr_q[24:20];
  assign id_funct7 = instr_q[31:25];

  // Per-opcode operand usage, immediate format and legality.
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    known_op = 1'b1;
    imm      = '0;
    case (id_opcode)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        use_rs1 = 1'b1;
        imm     = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      OPC_FENCE, OPC_SYSTEM: imm = {{20{instr_q[31]}}, instr_q[31:20]};
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                   instr_q[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: imm = {instr_q[31:12], 12'b0};
      OPC_JAL: imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                      instr_q[30:21], 1'b0};
      default: known_op = 1'b0;
    endcase
  end

  assign hazard = valid_q & ex_mem_read & (ex_rd != 5'd0) &
                  ((use_rs1 & (ex_rd == id_rs1)) | (use_rs2 & (ex_rd == id_rs2)));
  assign hold      = ex_stall | hazard;
  assign stall_out = hold;
  assign id_valid  = valid_q & ~hazard;
  assign id_pc     = pc_q;
  assign id_imm    = imm;
  assign id_illegal = valid_q & ~known_op;

  // IF/ID next state: flush beats hold, hold beats capture.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = if_pc;
      instr_d = if_instr;
      valid_d = if_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Writeback port; a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (REG_RESET && rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0) && !rst) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    id_rs1_data = '0;
    id_rs2_data = '0;
    if (id_rs1 != 5'd0) id_rs1_data = (wb_we && wb_rd == id_rs1) ? wb_data : rf_q[id_rs1];
    if (id_rs2 != 5'd0) id_rs2_data = (wb_we && wb_rd == id_rs2) ? wb_data : rf_q[id_rs2];
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vectors through an expected-value queue, then hand sequences
// for bypass, x0, load-use hazard, flush and mid-run reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr;
  logic        if_valid, flush, ex_stall, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_out, id_valid, id_illegal;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .flush(flush), .ex_stall(ex_stall), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_out(stall_out),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_illegal(id_illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam int W = 71;  // {valid, pc, rd, imm, illegal}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_imm;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic [31:0] pc, input logic [31:0] instr, input logic v);
    if_pc    = pc;
    if_instr = instr;
    if_valid = v;
  endtask

  initial begin
    rst = 1'b1; flush = 0; ex_stall = 0; ex_mem_read = 0; ex_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    drive_if(32'h0, 32'h0, 1'b0);
    step(); step();
    rst = 1'b0;

    check("rst_id_valid", 128'(id_valid), 128'(1'b0));
    check("rst_stall_out", 128'(stall_out), 128'(1'b0));
    check("rst_imm", 128'(id_imm), 128'(0));
    check("rst_rd", 128'(id_rd), 128'(0));
    check("rst_illegal", 128'(id_illegal), 128'(1'b0));
    check("rst_opcode", 128'(id_opcode), 128'(7'h13));

    vecs[0] = '{32'h00500093, 32'h0, 1'b1, 1'b1, 5'd1,  32'h00000005, 1'b0}; // addi x1,x0,5
    vecs[1] = '{32'hFE000CE3, 32'h0, 1'b1, 1'b1, 5'd25, 32'hFFFFFFF8, 1'b0}; // beq -8
    vecs[2] = '{32'h001000EF, 32'h0, 1'b1, 1'b1, 5'd1,  32'h00000800, 1'b0}; // jal x1,+2048
    vecs[3] = '{32'h123452B7, 32'h0, 1'b1, 1'b1, 5'd5,  32'h12345000, 1'b0}; // lui x5
    vecs[4] = '{32'h0020A423, 32'h0, 1'b1, 1'b1, 5'd8,  32'h00000008, 1'b0}; // sw x2,8(x1)
    vecs[5] = '{32'hFE20AFA3, 32'h0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0}; // sw x2,-1(x1)
    vecs[6] = '{32'h0000007F, 32'h0, 1'b1, 1'b1, 5'd0,  32'h00000000, 1'b1}; // bad opcode
    vecs[7] = '{32'h00500093, 32'h0, 1'b0, 1'b0, 5'd1,  32'h00000005, 1'b0}; // invalid slot
    vecs[8] = '{32'hFFFFF197, 32'h0, 1'b1, 1'b1, 5'd3,  32'hFFFFF000, 1'b0}; // auipc x3
    vecs[9] = '{32'hFFF08113, 32'h0, 1'b1, 1'b1, 5'd2,  32'hFFFFFFFF, 1'b0}; // addi x2,x1,-1
    vecs[0].pc = 32'h4;
    for (int i = 1; i < 10; i++) vecs[i].pc = 32'($urandom_range(1, 16'hFFFF)) << 2;

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      drive_if(vecs[i].pc, vecs[i].instr, vecs[i].valid);
      exp_q.push_back({vecs[i].exp_valid, vecs[i].pc, vecs[i].exp_rd, vecs[i].exp_imm,
                       vecs[i].exp_ill});
      step();
      a = {id_valid, id_pc, id_rd, id_imm, id_illegal};
      if (exp_q.size() == 0) begin
        check($sformatf("vec%0d_queue_empty", i), 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", i), 128'(a), 128'(e));
      end
    end

    // write-through bypass, then array read; ex_stall holds ID
    drive_if(32'h100, 32'h00018233, 1'b1); // add x4,x3,x0
    step();
    ex_stall = 1'b1;
    drive_if(32'h104, 32'h00500093, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    check("bypass_rs1", 128'(id_rs1_data), 128'(32'hDEADBEEF));
    check("exstall_valid", 128'(id_valid), 128'(1'b1));
    check("exstall_stall_out", 128'(stall_out), 128'(1'b1));
    step();
    wb_we = 1'b0;
    #1;
    check("array_rs1", 128'(id_rs1_data), 128'(32'hDEADBEEF));
    check("exstall_held_rd", 128'(id_rd), 128'(5'd4));
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    check("x0_bypass", 128'(id_rs2_data), 128'(0));
    step();
    wb_we = 1'b0;
    #1;
    check("x0_read", 128'(id_rs2_data), 128'(0));
    ex_stall = 1'b0;

    // load-use hazard on rs1, rs2, and none for ex_rd=0
    drive_if(32'h200, 32'h001102B3, 1'b1); // add x5,x2,x1
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    drive_if(32'h300, 32'h00500093, 1'b1);
    #1;
    check("hz_stall_out", 128'(stall_out), 128'(1'b1));
    check("hz_id_valid", 128'(id_valid), 128'(1'b0));
    step();
    check("hz_held_pc", 128'(id_pc), 128'(32'h200));
    check("hz_held_rd", 128'(id_rd), 128'(5'd5));
    ex_rd = 5'd1;
    #1;
    check("hz_rs2_stall", 128'(stall_out), 128'(1'b1));
    ex_rd = 5'd0;
    #1;
    check("hz_x0_nostall", 128'(stall_out), 128'(1'b0));
    ex_mem_read = 1'b0; ex_rd = 5'd2;
    #1;
    check("hz_clear_valid", 128'(id_valid), 128'(1'b1));
    step();
    check("hz_next_capture", 128'(id_pc), 128'(32'h300));
    drive_if(32'h304, 32'h123452B7, 1'b1); // lui x5 (rs1 field = 8)
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd8;
    #1;
    check("lui_nostall", 128'(stall_out), 128'(1'b0));
    check("lui_valid", 128'(id_valid), 128'(1'b1));
    ex_mem_read = 1'b0; ex_rd = 5'd0;

    // flush beats ex_stall, and beats hazard
    flush = 1'b1; ex_stall = 1'b1;
    step();
    flush = 1'b0; ex_stall = 1'b0;
    check("flush_valid", 128'(id_valid), 128'(1'b0));
    check("flush_nop", 128'(id_opcode), 128'(7'h13));
    check("flush_imm", 128'(id_imm), 128'(0));
    check("flush_pc", 128'(id_pc), 128'(0));
    drive_if(32'h500, 32'h001102B3, 1'b1);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2; flush = 1'b1;
    step();
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    check("flush_hz_valid", 128'(id_valid), 128'(1'b0));
    check("flush_hz_rd", 128'(id_rd), 128'(0));

    // reset mid-run: ID cleared, regfile cleared, WB write during reset dropped
    drive_if(32'h600, 32'h00018233, 1'b1);
    step();
    rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    step();
    rst = 1'b0; wb_we = 1'b0;
    check("midrst_valid", 128'(id_valid), 128'(1'b0));
    drive_if(32'h400, 32'h006183B3, 1'b1); // add x7,x3,x6
    step();
    check("midrst_capture_pc", 128'(id_pc), 128'(32'h400));
    check("midrst_capture_valid", 128'(id_valid), 128'(1'b1));
    check("midrst_x3_cleared", 128'(id_rs1_data), 128'(0));
    check("midrst_wb_dropped", 128'(id_rs2_data), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
